nfca_tx_scheduler: RTL
======================

Name: nfca_tx_scheduler

Overview:
Frame-level scheduler in front of the NFC-A controller's transmit stream. It shares the single tx stream between two requesters: host command frames from the UART parser FIFO, and internally generated periodic REQA poll frames. Frames are granted atomically. After each frame, the next grant waits until the controller reports the response end or a response timeout expires. It also maintains a card-present flag from poll results.

Parameters:
POLL_PERIOD, 8136000, clocks between auto-poll requests (100 ms at 81.36 MHz); must be >= 2
RESP_TIMEOUT, 81360, clocks to wait for rx end after the last tx beat (1 ms); must be >= 1
POLL_BYTE, 8'h26, data byte of the poll frame (REQA)
POLL_BITS, 4'd7, tdatab value of the poll frame (short frame, 7 bits)

Ports:
clk  input  1  system clock (81.36 MHz)
rstn  input  1  reset
poll_en  input  1  1: auto-polling enabled
h_tvalid  input  1  host frame beat valid
h_tready  output  1  host beat accepted
h_tdata  input  8  host byte
h_tdatab  input  4  host bit count, passed through unchanged
h_tlast  input  1  last beat of host frame
tx_tvalid  output  1  beat valid to controller
tx_tready  input  1  controller ready
tx_tdata  output  8  byte to controller
tx_tdatab  output  4  bit count to controller
tx_tlast  output  1  last beat to controller
rx_tvalid  input  1  controller rx beat valid
rx_tend  input  1  qualified by rx_tvalid; response finished
rx_terr  input  1  qualified by rx_tvalid & rx_tend; response had an error
busy  output  1  state != IDLE
resp_timeout  output  1  one-cycle pulse when the response timeout fires
card_present  output  1  last poll produced an error-free response

Behaviour:
- Reset: one clock and reset is synchronous, active-low (rstn=0 samples reset on clk rising edge). All registers clear: state=IDLE, poll counter=0, poll_pend=0, timeout counter=0, resp_timeout=0, card_present=0, busy=0. The tx_* and h_tready outputs are 0 in IDLE.
- States:
  - IDLE: no grant.
  - HOST_TX: host frame granted.
  - POLL_TX: single-beat poll frame driven.
  - WAIT_RSP: waiting for the response end or the timeout.
- Poll counter:
  - Increments every cycle while poll_en=1 and poll_pend=0.
  - On reaching POLL_PERIOD-1 it sets poll_pend and wraps to 0.
  - poll_en=0 clears both the counter and poll_pend.
  - Granting a host frame clears the counter (host activity defers polling); poll_pend is unaffected.
- IDLE arbitration, evaluated every cycle:
  - If h_tvalid=1, go to HOST_TX. Host has priority when both requesters are pending in the same cycle.
  - Otherwise, if poll_pend=1 and poll_en=1, go to POLL_TX and clear poll_pend.
  - The grant takes effect the cycle after the decision: one cycle of arbitration latency, and no tx_tvalid in IDLE.
- HOST_TX:
  - Combinational pass-through: tx_tvalid=h_tvalid, tx_tdata/tx_tdatab/tx_tlast = h_*, h_tready=tx_tready.
  - A beat transfers when tx_tvalid & tx_tready.
  - A transfer with h_tlast=1 moves the state to WAIT_RSP, with the source recorded as host.
  - The grant is held across host bubbles (h_tvalid=0 mid-frame); polls cannot interleave within a frame.
- POLL_TX:
  - Drives tx_tvalid=1, tx_tdata=POLL_BYTE, tx_tdatab=POLL_BITS, tx_tlast=1. h_tready=0.
  - Holds these values until tx_tready=1, then goes to WAIT_RSP with the source recorded as poll.
- WAIT_RSP:
  - The timeout counter starts at 0 on entry and increments each cycle.
  - rx_tvalid & rx_tend: return to IDLE. If the source is poll, card_present <= ~rx_terr; a host-sourced response leaves card_present unchanged.
  - Otherwise, when the counter reaches RESP_TIMEOUT-1: resp_timeout pulses for 1 cycle and the state returns to IDLE. If the source is poll, card_present <= 0.
  - rx_tend in the same cycle as the timeout terminal count: rx_tend wins and no resp_timeout pulse is produced.
  - rx_tvalid beats without rx_tend are ignored.
  - rx_tend seen in any other state is ignored.
- poll_en deasserted during POLL_TX or WAIT_RSP does not abort; the sequence completes normally.
- Reset asserted mid-frame returns to IDLE immediately. Any partial frame is abandoned; the downstream controller is reset by the same rstn.
- busy=1 in HOST_TX, POLL_TX and WAIT_RSP.

Test Plan:
- Reset, then poll_en=1 with POLL_PERIOD=10 and RESP_TIMEOUT=5, controller tx_tready=1, no rx response: poll beat {26h,7,last} appears; 5 cycles after acceptance resp_timeout pulses once; card_present stays 0; the next poll follows.
- Poll answered by rx_tvalid&rx_tend, rx_terr=0, 2 cycles after acceptance: card_present=1, no resp_timeout. The next poll answered with rx_terr=1: card_present=0.
- 3-beat host frame (11h,22h,33h last), with tx_tready toggling 1/0 and h_tvalid carrying a 1-cycle bubble: exactly 3 transfers in order with data/tdatab intact, h_tready=0 outside HOST_TX, and no poll inserted.
- h_tvalid and poll_pend both high in IDLE on the same cycle: host frame granted first; poll issued after the host's rx_tend.
- rx_tend coincident with the timeout terminal cycle: returns to IDLE, resp_timeout stays 0. A host-frame timeout leaves card_present=1 unchanged.
- rstn=0 for 1 cycle during WAIT_RSP and during the 2nd beat of a host frame: next cycle state=IDLE, busy=0, tx_tvalid=0, card_present=0, and the poll counter restarts from 0.

Source files
------------

// File: rtl/nfca_tx_scheduler.sv
// Frame-level arbiter for the NFC-A tx stream: host frames vs. periodic REQA polls,
// one frame in flight at a time, gated on the response end or a response timeout.
module nfca_tx_scheduler #(
  parameter int          POLL_PERIOD  = 8136000,
  parameter int          RESP_TIMEOUT = 81360,
  parameter logic [7:0]  POLL_BYTE    = 8'h26,
  parameter logic [3:0]  POLL_BITS    = 4'd7
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       poll_en,
  input  logic       h_tvalid,
  output logic       h_tready,
  input  logic [7:0] h_tdata,
  input  logic [3:0] h_tdatab,
  input  logic       h_tlast,
  output logic       tx_tvalid,
  input  logic       tx_tready,
  output logic [7:0] tx_tdata,
  output logic [3:0] tx_tdatab,
  output logic       tx_tlast,
  input  logic       rx_tvalid,
  input  logic       rx_tend,
  input  logic       rx_terr,
  output logic       busy,
  output logic       resp_timeout,
  output logic       card_present,
  output logic [1:0] state_dbg
);

  localparam int PW = (POLL_PERIOD  > 2) ? $clog2(POLL_PERIOD)  : 1;
  localparam int TW = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOST_TX  = 2'd1,
    POLL_TX  = 2'd2,
    WAIT_RSP = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic          poll_pend;
  logic [TW-1:0] to_cnt;
  logic          src_poll;

  // Valid/ready: a beat moves on a cycle where valid & ready are both high; the
  // source holds valid and payload stable until then. Host beats pass straight
  // through while HOST_TX owns the stream; the poll beat is held until accepted.
  always_comb begin
    tx_tvalid = 1'b0;
    tx_tdata  = 8'h00;
    tx_tdatab = 4'h0;
    tx_tlast  = 1'b0;
    h_tready  = 1'b0;
    case (state)
      HOST_TX: begin
        tx_tvalid = h_tvalid;
        tx_tdata  = h_tdata;
        tx_tdatab = h_tdatab;
        tx_tlast  = h_tlast;
        h_tready  = tx_tready;
      end
      POLL_TX: begin
        tx_tvalid = 1'b1;
        tx_tdata  = POLL_BYTE;
        tx_tdatab = POLL_BITS;
        tx_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      poll_cnt     <= '0;
      poll_pend    <= 1'b0;
      to_cnt       <= '0;
      src_poll     <= 1'b0;
      resp_timeout <= 1'b0;
      card_present <= 1'b0;
    end else begin
      resp_timeout <= 1'b0;

      // A host grant restarts the poll interval so polls never crowd host traffic.
      if (!poll_en) begin
        poll_cnt  <= '0;
        poll_pend <= 1'b0;
      end else begin
        if (state == IDLE && h_tvalid) begin
          poll_cnt <= '0;
        end else if (!poll_pend) begin
          if (poll_cnt == POLL_LAST) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        if (state == IDLE && !h_tvalid && poll_pend) poll_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (h_tvalid)                 state <= HOST_TX;
          else if (poll_pend && poll_en) state <= POLL_TX;
        end
        HOST_TX: begin
          if (h_tvalid && tx_tready && h_tlast) begin
            state    <= WAIT_RSP;
            src_poll <= 1'b0;
            to_cnt   <= '0;
          end
        end
        POLL_TX: begin
          if (tx_tready) begin
            state    <= WAIT_RSP;
            src_poll <= 1'b1;
            to_cnt   <= '0;
          end
        end
        WAIT_RSP: begin
          // A response end on the terminal count beats the timeout.
          if (rx_tvalid && rx_tend) begin
            state <= IDLE;
            if (src_poll) card_present <= ~rx_terr;
          end else if (to_cnt == TO_LAST) begin
            state        <= IDLE;
            resp_timeout <= 1'b1;
            if (src_poll) card_present <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
